// File: rtl/mips_mem_pkg.sv
// Shared MMIO offsets, register bit positions and address decode for the MIPS data-memory responder.
package mips_mem_pkg;

  localparam logic [15:0] OFF_TX_DATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS  = 16'h0004;
  localparam logic [15:0] OFF_CYCLE   = 16'h0008;
  localparam logic [15:0] OFF_ERR     = 16'h000C;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 2;
  localparam int STATUS_COUNT_W   = 7;

  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_MIS_BIT = 1;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TX,
    SEL_STATUS,
    SEL_CYCLE,
    SEL_ERR,
    SEL_NONE
  } sel_e;

  // Byte lanes addr[1:0] never take part in selecting a register or word.
  function automatic sel_e decode(input logic [31:0] a, input logic [15:0] base);
    sel_e s;
    if (a[31:16] != base) begin
      s = SEL_RAM;
    end else if (a[15:2] == OFF_TX_DATA[15:2]) begin
      s = SEL_TX;
    end else if (a[15:2] == OFF_STATUS[15:2]) begin
      s = SEL_STATUS;
    end else if (a[15:2] == OFF_CYCLE[15:2]) begin
      s = SEL_CYCLE;
    end else if (a[15:2] == OFF_ERR[15:2]) begin
      s = SEL_ERR;
    end else begin
      s = SEL_NONE;
    end
    return s;
  endfunction

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Data-memory port of the single-cycle core plus the TX byte stream leaving the responder.
interface mips_dmem_responder_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output memwrite, addr, writedata, tx_ready,
    input  readdata, tx_data, tx_valid
  );

  modport slave (
    input  memwrite, addr, writedata, tx_ready,
    output readdata, tx_data, tx_valid
  );
endinterface

// File: rtl/mips_dmem_fifo.sv
// Synchronous byte FIFO with simultaneous push/pop; a push into a full FIFO is kept only if a pop frees a slot.
module mips_dmem_fifo #(
  parameter  int FIFO_DEPTH = 8,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? 8'h00 : mem[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Zero-wait-state data memory for the single-cycle MIPS core: word RAM plus MMIO TX FIFO and cycle counter.
// Define MIPS_DMEM_ERR_EN to add the sticky ERR register (overflow / misaligned store) at offset 0x000C.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH      = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] MMIO_BASE  = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sel_e          sel;
  logic [AW-1:0] ram_idx;
  logic [31:0]   mem [DEPTH];
  logic          push, pop;
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   status;
  logic [31:0]   err_rd;

  assign sel     = decode(bus.addr, MMIO_BASE);
  assign ram_idx = bus.addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (bus.memwrite && sel == SEL_RAM) mem[ram_idx] <= bus.writedata;
  end

  assign push = bus.memwrite & (sel == SEL_TX);
  assign pop  = ~fifo_empty & bus.tx_ready;

  mips_dmem_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.writedata[7:0]),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.tx_valid = ~fifo_empty;
  assign bus.tx_data  = fifo_head;

  // A software write to CYCLE takes priority over that cycle's increment.
  assign cycle_d = (bus.memwrite && sel == SEL_CYCLE) ? bus.writedata : cycle_q + 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_q <= '0;
    else        cycle_q <= cycle_d;
  end

  always_comb begin
    status = '0;
    status[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
    status[STATUS_FULL_BIT]  = fifo_full;
    status[STATUS_EMPTY_BIT] = fifo_empty;
  end

`ifdef MIPS_DMEM_ERR_EN
  logic [1:0] err_q, err_d;
  logic       ovf_set, mis_set;

  assign ovf_set = push & fifo_full & ~pop;
  assign mis_set = bus.memwrite & (bus.addr[1:0] != 2'b00);

  // Write-1-to-clear is applied first so a same-cycle event still sets its flag.
  always_comb begin
    err_d = err_q;
    if (bus.memwrite && sel == SEL_ERR) err_d = err_q & ~bus.writedata[1:0];
    if (ovf_set) err_d[ERR_OVF_BIT] = 1'b1;
    if (mis_set) err_d[ERR_MIS_BIT] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_rd = {30'b0, err_q};
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^bus.addr[1:0];
  assign err_rd = '0;
`endif

  always_comb begin
    bus.readdata = '0;
    case (sel)
      SEL_RAM:    bus.readdata = mem[ram_idx];
      SEL_STATUS: bus.readdata = status;
      SEL_CYCLE:  bus.readdata = cycle_q;
      SEL_ERR:    bus.readdata = err_rd;
      default:    bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed-vector bench for mips_dmem_responder: stimulus queues expected loads/TX bytes, a monitor checks them.
module tb_mips_dmem_responder;

  localparam logic [31:0] A_TX     = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;
  localparam logic [31:0] A_ERR    = 32'hFFFF_000C;

  logic clk;
  logic reset;
  logic load_en;
  int   checks;
  int   errors;

  logic [31:0] rdq [$];
  logic [7:0]  txq [$];

  mips_dmem_responder_if bus ();

  mips_dmem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: loads are checked while load_en is high, TX bytes on every handshake.
  always @(negedge clk) begin
    if (load_en) begin
      if (rdq.size() == 0) chk("load_unexpected", bus.readdata, 32'hxxxx_xxxx);
      else                 chk("load", bus.readdata, rdq.pop_front());
    end
    if (bus.tx_valid && bus.tx_ready) begin
      if (txq.size() == 0) chk("tx_unexpected", {24'b0, bus.tx_data}, 32'hxxxx_xxxx);
      else                 chk("tx_byte", {24'b0, bus.tx_data}, {24'b0, txq.pop_front()});
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.addr      = a;
    bus.writedata = d;
    @(posedge clk);
    #1;
    bus.memwrite  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp);
    bus.memwrite = 1'b0;
    bus.addr     = a;
    rdq.push_back(exp);
    load_en      = 1'b1;
    @(posedge clk);
    #1;
    load_en      = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    if (accepted) txq.push_back(b);
    store(A_TX, {24'hABCDEF, b});
  endtask

  task automatic drain();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (txq.size() == 0 && !bus.tx_valid) break;
      @(posedge clk);
      #1;
    end
    bus.tx_ready = 1'b0;
    chk("drain_valid_low", {31'b0, bus.tx_valid}, 32'd0);
    chk("drain_queue_empty", txq.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    checks        = 0;
    errors        = 0;
    load_en       = 1'b0;
    reset         = 1'b0;
    bus.memwrite  = 1'b0;
    bus.addr      = '0;
    bus.writedata = '0;
    bus.tx_ready  = 1'b0;

    // Reset state
    #1;
    chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
    @(posedge clk);
    #1;
    load(A_STATUS, 32'h0000_0001);
    load(A_CYCLE, 32'h0000_0000);
    reset = 1'b1;

    // RAM store/load, byte lanes ignored, neighbour untouched
    store(32'h0000_0014, 32'h1234_5678);
    store(32'h0000_0010, 32'hDEAD_BEEF);
    load(32'h0000_0010, 32'hDEAD_BEEF);
    load(32'h0000_0013, 32'hDEAD_BEEF);
    load(32'h0000_0014, 32'h1234_5678);

    // Two pushes held, then drained in order
    push_byte(8'h41, 1'b1);
    push_byte(8'h42, 1'b1);
    chk("tx_valid_held", {31'b0, bus.tx_valid}, 32'd1);
    chk("tx_head_held", {24'b0, bus.tx_data}, 32'h41);
    load(A_STATUS, 32'h0000_0008);
    drain();
    load(A_STATUS, 32'h0000_0001);

    // Overfill: ninth byte dropped
    for (int i = 0; i < 9; i++) push_byte(8'(i), i < 8);
    load(A_STATUS, 32'h0000_0022);
`ifdef MIPS_DMEM_ERR_EN
    load(A_ERR, 32'h0000_0001);
    store(A_ERR, 32'h0000_0003);
    load(A_ERR, 32'h0000_0000);
`else
    load(A_ERR, 32'h0000_0000);
    store(A_ERR, 32'h0000_0003);
`endif

    // Full FIFO with simultaneous pop and push keeps count at 8
    bus.tx_ready = 1'b1;
    push_byte(8'h55, 1'b1);
    bus.tx_ready = 1'b0;
    load(A_STATUS, 32'h0000_0022);
    drain();
    load(A_STATUS, 32'h0000_0001);

    // Cycle counter wrap
    store(A_CYCLE, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    load(A_CYCLE, 32'hFFFF_FFFF);
    load(A_CYCLE, 32'h0000_0000);

    // Read-only / unmapped MMIO must not disturb STATUS or RAM
    store(A_STATUS, 32'hFFFF_FFFF);
    load(A_STATUS, 32'h0000_0001);
    store(32'hFFFF_0010, 32'h0BAD_0BAD);
    load(32'hFFFF_0010, 32'h0000_0000);
    load(32'h0000_0010, 32'hDEAD_BEEF);
    load(A_TX, 32'h0000_0000);

    // Misaligned store lands word-aligned
    store(32'h0000_0016, 32'hCAFE_F00D);
    load(32'h0000_0014, 32'hCAFE_F00D);
`ifdef MIPS_DMEM_ERR_EN
    load(A_ERR, 32'h0000_0002);
    store(32'hFFFF_000E, 32'h0000_0002);
    load(A_ERR, 32'h0000_0002);
    store(A_ERR, 32'h0000_0003);
    load(A_ERR, 32'h0000_0000);
`else
    load(A_ERR, 32'h0000_0000);
`endif

    // Asynchronous reset in the middle of a pending stream
    push_byte(8'h61, 1'b1);
    push_byte(8'h62, 1'b1);
    push_byte(8'h63, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
    txq.delete();
    load(A_STATUS, 32'h0000_0001);
    reset = 1'b1;
    load(A_CYCLE, 32'h0000_0000);
    load(A_CYCLE, 32'h0000_0001);
    load(A_STATUS, 32'h0000_0001);

    @(negedge clk);
    chk("load_queue_empty", rdq.size(), 32'd0);
    chk("tx_queue_empty", txq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
